// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and encodings for the multiplier-sharing sequencer:
// FSM states, shifter select codes and nibble select codes.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] SHIFT_0 = 2'b00;
    localparam logic [1:0] SHIFT_4 = 2'b01;
    localparam logic [1:0] SHIFT_8 = 2'b10;

    localparam logic NIB_LO = 1'b0;
    localparam logic NIB_HI = 1'b1;

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap
// and returns the first active requester as one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IDW-1:0]  win_idx
);

    logic found;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + i) % NREQ)) begin
                    found     = 1'b1;
                    win_oh[j] = 1'b1;
                    win_idx   = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Sequencer sharing one nibble-serial 8x8 multiply datapath among NREQ requesters.
// Optional macro ZERO_SKIP_EN: a zero operand bypasses the four MUL steps.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] a_in,
    input  logic [8*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [7:0]        op_a,
    output logic [7:0]        op_b,
    output logic              sela,
    output logic              selb,
    output logic [1:0]        sel_shift,
    output logic              acc_clr,
    output logic              acc_en,
    input  logic [15:0]       acc,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [15:0]       res_data,
    input  logic              res_ready
);

    state_e          state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_idx;
    logic [7:0]      win_a, win_b;
`ifdef ZERO_SKIP_EN
    logic            zero_q, zero_d;
`endif

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .win_oh (win_oh),
        .win_idx(win_idx)
    );

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_a = a_in[8*i +: 8];
                win_b = b_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            ptr_q    <= IDW'(NREQ - 1);
            res_id_q <= '0;
            gnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
`ifdef ZERO_SKIP_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            ptr_q    <= ptr_d;
            res_id_q <= res_id_d;
            gnt_q    <= gnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
`ifdef ZERO_SKIP_EN
            zero_q   <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        ptr_d     = ptr_q;
        res_id_d  = res_id_q;
        gnt_d     = '0;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
`ifdef ZERO_SKIP_EN
        zero_d    = zero_q;
`endif
        sela      = NIB_LO;
        selb      = NIB_LO;
        sel_shift = SHIFT_0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = win_oh;
                    op_a_d   = win_a;
                    op_b_d   = win_b;
                    res_id_d = win_idx;
                    ptr_d    = win_idx;
                    step_d   = '0;
                    state_d  = MUL;
`ifdef ZERO_SKIP_EN
                    zero_d = (win_a == 8'h00) || (win_b == 8'h00);
                    if (zero_d) state_d = DONE;
`endif
                end
            end
            MUL: begin
                // Partial products: lo*lo, lo*hi<<4, hi*lo<<4, hi*hi<<8
                acc_en = 1'b1;
                case (step_q)
                    2'd0: acc_clr = 1'b1;
                    2'd1: begin selb = NIB_HI; sel_shift = SHIFT_4; end
                    2'd2: begin sela = NIB_HI; sel_shift = SHIFT_4; end
                    2'd3: begin sela = NIB_HI; selb = NIB_HI; sel_shift = SHIFT_8; end
                endcase
                if (step_q == 2'd3) state_d = DONE;
                else                step_d  = step_q + 2'd1;
            end
            DONE: begin
`ifdef ZERO_SKIP_EN
                // A skipped operation lands here in its grant cycle; publish one cycle later
                res_valid = !(|gnt_q);
                res_data  = zero_q ? 16'h0000 : acc;
`else
                res_valid = 1'b1;
                res_data  = acc;
`endif
                if (res_valid && res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt    = gnt_q;
    assign busy   = (state_q != IDLE);
    assign op_a   = op_a_q;
    assign op_b   = op_b_q;
    assign res_id = res_id_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl with a behavioural datapath and
// a cycle-level reference model of arbitration, latency and products.
module tb_mult_share_ctrl;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] a_in, b_in;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [7:0]        op_a, op_b;
    logic              sela, selb;
    logic [1:0]        sel_shift;
    logic              acc_clr, acc_en;
    logic [15:0]       acc = 16'h0;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [15:0]       res_data;
    logic              res_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .gnt      (gnt),
        .busy     (busy),
        .op_a     (op_a),
        .op_b     (op_b),
        .sela     (sela),
        .selb     (selb),
        .sel_shift(sel_shift),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en),
        .acc      (acc),
        .res_valid(res_valid),
        .res_id   (res_id),
        .res_data (res_data),
        .res_ready(res_ready)
    );

    // Datapath: 4x4 multiplier, shifter, 16-bit accumulator
    logic [3:0]  nib_a, nib_b;
    logic [15:0] pp;
    always_comb begin
        nib_a = sela ? op_a[7:4] : op_a[3:0];
        nib_b = selb ? op_b[7:4] : op_b[3:0];
        pp    = 16'(nib_a) * 16'(nib_b);
        case (sel_shift)
            2'b01:   pp = pp << 4;
            2'b10:   pp = pp << 8;
            default: pp = pp;
        endcase
    end
    always @(posedge clk) if (acc_en) acc <= (acc_clr ? 16'h0 : acc) + pp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; a_in = '0; b_in = '0; res_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({gnt, busy, res_valid, acc_en, acc_clr} !== '0) begin
            n_bad++; $display("FAIL reset_ctrl: got gnt=%b busy=%b vld=%b en=%b clr=%b, expected all 0",
                              gnt, busy, res_valid, acc_en, acc_clr);
        end
        n_cmp++;
        if ({op_a, op_b} !== 16'h0) begin
            n_bad++; $display("FAIL reset_ops: got op_a=%h op_b=%h, expected 00 00", op_a, op_b);
        end
        n_cmp++;
        if ({sela, selb, sel_shift} !== 4'b0) begin
            n_bad++; $display("FAIL reset_sel: got %b, expected 0000", {sela, selb, sel_shift});
        end
        n_cmp++;
        if ({res_id, res_data} !== '0) begin
            n_bad++; $display("FAIL reset_res: got id=%0d data=%h, expected 0 0000", res_id, res_data);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || gnt !== '0) begin
            n_bad++; $display("FAIL reset_idle: got busy=%b gnt=%b, expected 0 0", busy, gnt);
        end
    endtask

    task automatic test_single();
        logic [1:0] ab_tab [4];
        logic [1:0] sh_tab [4];
        logic [5:0] exp_ctl;
        ab_tab = '{2'b00, 2'b01, 2'b10, 2'b11};
        sh_tab = '{2'b00, 2'b01, 2'b01, 2'b10};
        a_in = '0; b_in = '0;
        a_in[7:0] = 8'h12; b_in[7:0] = 8'h34;
        res_ready = 1'b1; req = 2'b01;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            tick();
            n_cmp++;
            if (gnt !== (cyc == 1 ? 2'b01 : 2'b00)) begin
                n_bad++; $display("FAIL single_gnt c%0d: got %b", cyc, gnt);
            end
            if (cyc <= 4) begin
                exp_ctl = {ab_tab[cyc-1], sh_tab[cyc-1], (cyc == 1), 1'b1};
                n_cmp++;
                if ({sela, selb, sel_shift, acc_clr, acc_en} !== exp_ctl) begin
                    n_bad++; $display("FAIL single_ctl c%0d: got %b expected %b", cyc,
                                      {sela, selb, sel_shift, acc_clr, acc_en}, exp_ctl);
                end
            end
            n_cmp++;
            if (res_valid !== (cyc == 5)) begin
                n_bad++; $display("FAIL single_vld c%0d: got %b", cyc, res_valid);
            end
            req = '0;
        end
        n_cmp++;
        if (res_data !== 16'h03A8 || res_id !== 2'd0) begin
            n_bad++; $display("FAIL single_res: got %h id %0d expected 03a8 id 0", res_data, res_id);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_idle: got busy=%b vld=%b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_simul();
        bit ok;
        do_reset();
        res_ready = 1'b1;
        a_in = {8'h10, 8'hFF}; b_in = {8'h10, 8'hFF}; req = 2'b11;
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== 2'b01) begin
            n_bad++; $display("FAIL simul_gnt0: got %b expected 01 (ok=%0d)", gnt, ok);
        end
        req = 2'b10;
        wait_valid(ok);
        n_cmp++;
        if (!ok || res_data !== 16'hFE01 || res_id !== 2'd0) begin
            n_bad++; $display("FAIL simul_res0: got %h id %0d expected fe01 id 0", res_data, res_id);
        end
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== 2'b10) begin
            n_bad++; $display("FAIL simul_gnt1: got %b expected 10 (ok=%0d)", gnt, ok);
        end
        req = '0;
        wait_valid(ok);
        n_cmp++;
        if (!ok || res_data !== 16'h0100 || res_id !== 2'd1) begin
            n_bad++; $display("FAIL simul_res1: got %h id %0d expected 0100 id 1", res_data, res_id);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int served, since, w, exp_w, cyc;
        logic [NREQ-1:0] oh;
        logic [15:0] expd;
        a_in = 16'($urandom); b_in = 16'($urandom);
        req = 2'b11; res_ready = 1'b1;
        served = 0; since = 100; w = 0; exp_w = 0; cyc = 0;
        while (served < 4 && cyc < 80) begin
            tick(); cyc++; since++;
            if (gnt !== '0) begin
                oh = '0; oh[exp_w] = 1'b1;
                n_cmp++;
                if (gnt !== oh || since < 6) begin
                    n_bad++; $display("FAIL b2b_gnt: got %b expected %b spacing %0d", gnt, oh, since);
                end
                w = exp_w; exp_w = (exp_w + 1) % NREQ; since = 0;
            end
            if (res_valid) begin
                expd = 16'(a_in[8*w +: 8]) * 16'(b_in[8*w +: 8]);
                n_cmp++;
                if (res_data !== expd || res_id !== IDW'(w)) begin
                    n_bad++; $display("FAIL b2b_res: got %h id %0d expected %h id %0d", res_data, res_id, expd, w);
                end
                served++;
                if (served == 4) req = '0;
            end
        end
        n_cmp++;
        if (served != 4) begin
            n_bad++; $display("FAIL b2b_count: got %0d results expected 4", served);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [15:0] d;
        logic [IDW-1:0] id;
        a_in[7:0] = 8'($urandom_range(1, 255)); b_in[7:0] = 8'($urandom_range(1, 255));
        req = 2'b01; res_ready = 1'b0;
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== 2'b01) begin
            n_bad++; $display("FAIL bp_gnt: got %b expected 01", gnt);
        end
        req = 2'b10; a_in[15:8] = 8'h21; b_in[15:8] = 8'h03;
        wait_valid(ok);
        n_cmp++;
        if (!ok || res_data !== 16'(a_in[7:0]) * 16'(b_in[7:0]) || res_id !== 2'd0) begin
            n_bad++; $display("FAIL bp_res: got %h id %0d", res_data, res_id);
        end
        d = res_data; id = res_id;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== d || res_id !== id || gnt !== '0) begin
                n_bad++; $display("FAIL bp_hold%0d: got vld=%b data=%h id=%0d gnt=%b expected 1 %h %0d 00",
                                  i, res_valid, res_data, res_id, gnt, d, id);
            end
        end
        res_ready = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_idle: got busy=%b vld=%b expected 0 0", busy, res_valid);
        end
        tick();
        n_cmp++;
        if (gnt !== 2'b10) begin
            n_bad++; $display("FAIL bp_gnt1: got %b expected 10", gnt);
        end
        req = '0;
        wait_valid(ok);
        n_cmp++;
        if (!ok || res_data !== 16'h0063 || res_id !== 2'd1) begin
            n_bad++; $display("FAIL bp_res1: got %h id %0d expected 0063 id 1", res_data, res_id);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        a_in[7:0] = 8'hA5; b_in[7:0] = 8'h5A; req = 2'b01; res_ready = 1'b1;
        wait_gnt(ok);
        req = '0;
        tick(); tick();
        n_cmp++;
        if (!ok || {sela, selb, sel_shift} !== 4'b1001) begin
            n_bad++; $display("FAIL rmid_step2: got %b expected 1001", {sela, selb, sel_shift});
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({gnt, busy, res_valid, acc_en, acc_clr, sela, selb, sel_shift, op_a, op_b, res_id, res_data} !== '0) begin
            n_bad++; $display("FAIL rmid_reset: got busy=%b vld=%b en=%b op_a=%h data=%h expected zeros",
                              busy, res_valid, acc_en, op_a, res_data);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (res_valid || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++; $display("FAIL rmid_abort: got activity after reset, expected none");
        end
        a_in[7:0] = 8'h0F; b_in[7:0] = 8'h0F; req = 2'b01;
        wait_gnt(ok);
        req = '0;
        wait_valid(ok);
        n_cmp++;
        if (!ok || res_data !== 16'h00E1 || res_id !== 2'd0) begin
            n_bad++; $display("FAIL rmid_res: got %h id %0d expected 00e1 id 0", res_data, res_id);
        end
        tick();
    endtask

    task automatic test_random();
        int phase, w_m, ptr_m, c;
        logic [15:0] prod_m;
        logic [NREQ-1:0] oh;
        do_reset();
        a_in = '0; b_in = '0;
        phase = 0; w_m = 0; ptr_m = NREQ - 1; prod_m = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            oh = '0;
            if (phase == 1) oh[w_m] = 1'b1;
            n_cmp++;
            if (gnt !== oh) begin
                n_bad++; $display("FAIL rnd_gnt c%0d: got %b expected %b", cyc, gnt, oh);
            end
            n_cmp++;
            if (busy !== (phase != 0) || res_valid !== (phase == 5)) begin
                n_bad++; $display("FAIL rnd_state c%0d: got busy=%b vld=%b expected phase %0d", cyc, busy, res_valid, phase);
            end
            if (phase == 5) begin
                n_cmp++;
                if (res_data !== prod_m || res_id !== IDW'(w_m)) begin
                    n_bad++; $display("FAIL rnd_res c%0d: got %h id %0d expected %h id %0d", cyc, res_data, res_id, prod_m, w_m);
                end
            end
            if (phase == 1) begin
                req[w_m] = 1'b0;
                a_in[8*w_m +: 8] = 8'($urandom_range(1, 255));
                b_in[8*w_m +: 8] = 8'($urandom_range(1, 255));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    a_in[8*i +: 8] = 8'($urandom_range(1, 255));
                    b_in[8*i +: 8] = 8'($urandom_range(1, 255));
                end
            end
            res_ready = 1'($urandom_range(0, 1));
            if (phase == 0) begin
                if (req != '0) begin
                    w_m = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        c = (ptr_m + k) % NREQ;
                        if (w_m < 0 && req[c]) w_m = c;
                    end
                    ptr_m  = w_m;
                    prod_m = 16'(a_in[8*w_m +: 8]) * 16'(b_in[8*w_m +: 8]);
                    phase  = 1;
                end
            end else if (phase < 5) begin
                phase++;
            end else if (res_ready) begin
                phase = 0;
            end
        end
        req = '0; res_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
    endtask

`ifdef ZERO_SKIP_EN
    task automatic test_zero_skip();
        bit seen_en;
        do_reset();
        res_ready = 1'b1;
        a_in[7:0] = 8'h00; b_in[7:0] = 8'h7B; req = 2'b01;
        seen_en = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            tick();
            if (acc_en) seen_en = 1'b1;
            if (cyc == 1) begin
                n_cmp++;
                if (gnt !== 2'b01 || res_valid !== 1'b0) begin
                    n_bad++; $display("FAIL zs_gnt: got gnt=%b vld=%b expected 01 0", gnt, res_valid);
                end
            end
            if (cyc == 2) begin
                n_cmp++;
                if (res_valid !== 1'b1 || res_data !== 16'h0 || res_id !== 2'd0) begin
                    n_bad++; $display("FAIL zs_res: got vld=%b data=%h id=%0d expected 1 0000 0", res_valid, res_data, res_id);
                end
            end
            req = '0;
        end
        n_cmp++;
        if (seen_en) begin
            n_bad++; $display("FAIL zs_acc_en: got acc_en high, expected never");
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
        test_reset();
        test_single();
        test_simul();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef ZERO_SKIP_EN
        test_zero_skip();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Sequencer and round-robin arbiter that shares one nibble-serial 8x8 multiply datapath between NREQ requesters. The datapath is a 4x4 multiplier, a shifter and a 16-bit accumulator register. The block accepts one request, latches its operands and drives the nibble selects, shift select and accumulator controls for four partial-product steps. It then presents the 16-bit product, tagged with the requester id, under a valid/ready handshake.

Parameters:
NREQ, 2, number of requesters (legal 2..4)
IDW, 2, width of result id (ceil(log2 NREQ), min 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request level; held until gnt
a_in  in  8*NREQ  operand A of requester i at [8i+7:8i]
b_in  in  8*NREQ  operand B of requester i at [8i+7:8i]
gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured
busy  out  1  high in any state other than IDLE
op_a  out  8  latched operand A to datapath nibble mux
op_b  out  8  latched operand B to datapath nibble mux
sela  out  1  1 = high nibble of op_a, 0 = low nibble
selb  out  1  1 = high nibble of op_b, 0 = low nibble
sel_shift  out  2  00 = <<0, 01 = <<4, 10 = <<8, 11 = unused
acc_clr  out  1  adder uses 0 instead of accumulator feedback
acc_en  out  1  accumulator register load enable
acc  in  16  accumulator register output
res_valid  out  1  product available
res_id  out  IDW  index of requester owning the result
res_data  out  16  product
res_ready  in  1  consumer accepts result when high with res_valid

Behaviour:
- Reset values: gnt=0, busy=0, op_a=op_b=0, sela=selb=0, sel_shift=00, acc_clr=0, acc_en=0, res_valid=0, res_id=0, res_data=0.
- Round-robin pointer resets to NREQ-1, so requester 0 has top priority first.
- Reset at any point aborts the operation: no res_valid, no gnt, state returns to IDLE.
- States: IDLE, MUL, DONE.
- IDLE: if req != 0, pick the winner by searching upward from pointer+1 with wrap. Register gnt[winner]=1, op_a/op_b = winner's operands, res_id=winner, pointer=winner, step=0, go to MUL. If req == 0, stay in IDLE.
- gnt is high during the first MUL cycle only.
- MUL: step counter 0..3, one cycle per step; acc_en=1 in every MUL cycle.
  - step0: sela=0, selb=0, sel_shift=00, acc_clr=1
  - step1: sela=0, selb=1, sel_shift=01, acc_clr=0
  - step2: sela=1, selb=0, sel_shift=01, acc_clr=0
  - step3: sela=1, selb=1, sel_shift=10, acc_clr=0; then go to DONE
- Outside MUL: acc_en=0 and acc_clr=0.
- DONE: res_valid=1, res_data=acc. Hold res_valid, res_data and res_id stable until res_ready=1, then go to IDLE.
- res_ready is ignored outside DONE.
- Latency: req seen in IDLE at cycle 0 -> gnt in cycle 1 -> res_valid in cycle 5. Minimum spacing between grants is 6 cycles.
- req changes after capture have no effect on the operation in flight.
- A req still high in IDLE after its gnt counts as a new request.
- The datapath adder is modulo 2^16; the product of 8-bit operands never overflows (max 0xFE01).
- Simultaneous requests: exactly one gnt bit per arbitration; losers stay pending.

Optional Feature:
ZERO_SKIP_EN
- Defined: in IDLE, if the winner's a or b == 0, gnt and capture proceed as normal. The state goes directly to DONE with res_data=0 and MUL is skipped (acc_en never asserted). Latency is 2 cycles.
- Undefined: every operation runs all four MUL steps.

Decomposition:
- Package mult_share_pkg:
  - state enum (IDLE, MUL, DONE)
  - SHIFT_0 = 2'b00, SHIFT_4 = 2'b01, SHIFT_8 = 2'b10
  - NIB_LO = 1'b0, NIB_HI = 1'b1
- Sub-module rr_arbiter (inputs req, pointer; output one-hot winner and index), purely combinational. The FSM and step counter stay in mult_share_ctrl.

Test Plan:
- req=01, a0=0x12, b0=0x34, res_ready=1 -> gnt=01 in cycle 1; steps issue select sequence 00/00, 01/01, 10/01, 11/10; res_valid in cycle 5 with res_data=0x03A8, res_id=0.
- req=11 in the same cycle, a0=b0=0xFF, a1=b1=0x10 -> requester 0 served first with 0xFE01, then requester 1 with 0x0100.
- req=11 held continuously for 4 operations -> gnt order 0,1,0,1; no gnt while busy.
- DONE with res_ready=0 for 3 cycles -> res_valid, res_data and res_id stable; no gnt; IDLE one cycle after res_ready=1.
- rst pulsed during step2 -> outputs at reset values next cycle, no res_valid; next request 0x0F*0x0F returns 0x00E1.
- ZERO_SKIP_EN defined, a0=0x00, b0=0x7B -> res_valid in cycle 2 with res_data=0, acc_en never high.
